// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - KxK sliding-window convolution sequencer over an IMG_W x IMG_W image
// Optional build macro CONV_SEQUENCER_RELU_EN clamps negative saturated results to zero.
module conv_sequencer #(
    parameter int IMG_W = 28,
    parameter int K     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  bias,
    input  logic        wgt_we,
    input  logic [3:0]  wgt_addr,
    input  logic [7:0]  wgt_data,
    output logic        img_rd,
    output logic [9:0]  img_addr,
    input  logic [7:0]  img_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [9:0]  out_addr,
    output logic [15:0] out_data,
    output logic        busy,
    output logic        done
);
    localparam int OUT_W = IMG_W - K + 1;
    localparam int NTAPS = K * K;
    localparam logic [9:0] IW   = 10'(IMG_W);
    localparam logic [9:0] OW   = 10'(OUT_W);
    localparam logic [9:0] OWM1 = 10'(OUT_W - 1);
    localparam logic [9:0] KM1  = 10'(K - 1);
    localparam logic [4:0] NT5  = 5'(NTAPS);

    typedef enum logic [2:0] {IDLE, FETCH, LAST, WRITE, DONE} state_t;
    state_t state;

    logic signed [7:0]  weights [NTAPS];
    logic signed [7:0]  bias_r;
    logic signed [19:0] acc;
    logic [9:0] orow, ocol, kr, kc;
    logic [3:0] tap, pend_tap;
    logic       pend_valid;

    logic               tap_last, pix_last;
    logic [9:0]         kr_n, kc_n, orow_n, ocol_n;
    logic [9:0]         tap_addr, pix_addr, pix_idx;
    logic signed [16:0] prod;
    logic signed [19:0] acc_sum;
    logic [15:0]        result;

    // Products land one cycle after their read, tracked by pend_valid/pend_tap.
    always_comb begin
        tap_last = (kr == KM1) && (kc == KM1);
        kc_n     = (kc == KM1) ? 10'd0 : kc + 10'd1;
        kr_n     = (kc == KM1) ? kr + 10'd1 : kr;
        tap_addr = (orow + kr_n) * IW + ocol + kc_n;
        pix_last = (orow == OWM1) && (ocol == OWM1);
        ocol_n   = (ocol == OWM1) ? 10'd0 : ocol + 10'd1;
        orow_n   = (ocol == OWM1) ? orow + 10'd1 : orow;
        pix_addr = orow_n * IW + ocol_n;
        pix_idx  = orow * OW + ocol;
        prod     = $signed({9'd0, img_data}) *
                   $signed({{9{weights[pend_tap][7]}}, weights[pend_tap]});
        acc_sum  = acc + (pend_valid ? {{3{prod[16]}}, prod} : 20'sd0);
        if (acc_sum > 20'sd32767)
            result = 16'h7fff;
        else if (acc_sum < -20'sd32768)
            result = 16'h8000;
        else
            result = acc_sum[15:0];
`ifdef CONV_SEQUENCER_RELU_EN
        if (result[15])
            result = 16'd0;
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            out_valid  <= 1'b0;
            img_rd     <= 1'b0;
            img_addr   <= 10'd0;
            out_addr   <= 10'd0;
            out_data   <= 16'd0;
            acc        <= 20'sd0;
            orow       <= 10'd0;
            ocol       <= 10'd0;
            kr         <= 10'd0;
            kc         <= 10'd0;
            tap        <= 4'd0;
            pend_tap   <= 4'd0;
            pend_valid <= 1'b0;
            bias_r     <= 8'sd0;
            for (int i = 0; i < NTAPS; i++)
                weights[i] <= 8'sd0;
        end else begin
            done       <= 1'b0;
            pend_valid <= img_rd;
            pend_tap   <= tap;
            case (state)
                IDLE: begin
                    if (wgt_we && ({1'b0, wgt_addr} < NT5))
                        weights[wgt_addr] <= wgt_data;
                    if (start) begin
                        state    <= FETCH;
                        busy     <= 1'b1;
                        bias_r   <= bias;
                        acc      <= {{12{bias[7]}}, bias};
                        orow     <= 10'd0;
                        ocol     <= 10'd0;
                        kr       <= 10'd0;
                        kc       <= 10'd0;
                        tap      <= 4'd0;
                        img_rd   <= 1'b1;
                        img_addr <= 10'd0;
                    end
                end
                FETCH: begin
                    acc <= acc_sum;
                    if (tap_last) begin
                        state  <= LAST;
                        img_rd <= 1'b0;
                    end else begin
                        kr       <= kr_n;
                        kc       <= kc_n;
                        tap      <= tap + 4'd1;
                        img_addr <= tap_addr;
                    end
                end
                LAST: begin
                    acc       <= acc_sum;
                    out_data  <= result;
                    out_addr  <= pix_idx;
                    out_valid <= 1'b1;
                    state     <= WRITE;
                end
                WRITE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (pix_last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            orow     <= orow_n;
                            ocol     <= ocol_n;
                            kr       <= 10'd0;
                            kc       <= 10'd0;
                            tap      <= 4'd0;
                            acc      <= {{12{bias_r[7]}}, bias_r};
                            img_rd   <= 1'b1;
                            img_addr <= pix_addr;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_sequencer.sv
// tb/tb_conv_sequencer.sv - randomized self-checking bench for conv_sequencer against an arithmetic reference
module tb_conv_sequencer;
    localparam int IMG_W = 28;
    localparam int K     = 3;
    localparam int OUT_W = IMG_W - K + 1;
    localparam int NPIX  = OUT_W * OUT_W;
    localparam int NT    = K * K;
    localparam int PASS_CYC = NPIX * (NT + 2) + 1;

    logic        clk = 1'b0;
    logic        reset, start, wgt_we, out_ready;
    logic [7:0]  bias, wgt_data, img_data;
    logic [3:0]  wgt_addr;
    logic        img_rd, out_valid, busy, done;
    logic [9:0]  img_addr, out_addr;
    logic [15:0] out_data;

    int img_mem [IMG_W*IMG_W];
    int w_model [NT];
    int bias_model;
    int n_vec = 0;
    int n_fail = 0;
    int first_data;
    int rd_q[$];

    conv_sequencer #(.IMG_W(IMG_W), .K(K)) dut (
        .clk(clk), .reset(reset), .start(start), .bias(bias),
        .wgt_we(wgt_we), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
        .img_rd(img_rd), .img_addr(img_addr), .img_data(img_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Image memory: data appears the cycle after the read strobe.
    always @(posedge clk)
        if (img_rd && img_addr < 10'(IMG_W*IMG_W))
            img_data <= 8'(img_mem[img_addr]);

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_pixel(input int p);
        int orow = p / OUT_W;
        int ocol = p % OUT_W;
        int s = bias_model;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                s += img_mem[(orow + r) * IMG_W + ocol + c] * w_model[r * K + c];
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`ifdef CONV_SEQUENCER_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic load_weights();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wgt_we   = 1'b1;
            wgt_addr = 4'(i);
            wgt_data = (i < NT) ? 8'(w_model[i]) : 8'($urandom_range(1, 255));
        end
        @(negedge clk);
        wgt_we = 1'b0;
    endtask

    task automatic run_pass(input int stall_pix, input int abort_pix, input int exp_done, input bit poke);
        int hs = 0, cyc = 0, stall = 0, sd = 0, sa = 0;
        bit fin = 1'b0;
        rd_q.delete();
        @(negedge clk);
        bias = 8'(bias_model);
        start = 1'b1;
        out_ready = 1'b1;
        while (!fin && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            start  = 1'b0;
            wgt_we = 1'b0;
            if (cyc == 1) begin
                check("busy_c1", busy, 1);
                check("rd_c1", img_rd, 1);
                check("addr_c1", img_addr, 0);
            end
            if (poke && cyc == 50) begin
                start = 1'b1; wgt_we = 1'b1; wgt_addr = 4'd4; wgt_data = 8'h55; bias = ~bias;
            end
            if (img_rd) rd_q.push_back(int'(img_addr));
            if (abort_pix >= 0 && hs == abort_pix && img_rd) begin
                reset = 1'b1;
                @(negedge clk);
                check("abort_busy", busy, 0);
                check("abort_valid", out_valid, 0);
                check("abort_rd", img_rd, 0);
                reset = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("post_abort_rd", img_rd, 0);
                    check("post_abort_valid", out_valid, 0);
                end
                return;
            end
            if (out_valid && int'(out_addr) == stall_pix && stall < 5) begin
                if (stall == 0) begin
                    sd = int'($signed(out_data));
                    sa = int'(out_addr);
                end else begin
                    check("stall_data", int'($signed(out_data)), sd);
                    check("stall_addr", int'(out_addr), sa);
                end
                check("stall_rd", img_rd, 0);
                stall++;
                out_ready = 1'b0;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (hs == 0) first_data = int'($signed(out_data));
                check("out_addr", int'(out_addr), hs);
                check("out_data", int'($signed(out_data)), ref_pixel(hs));
                hs++;
            end
            if (done) begin
                fin = 1'b1;
                check("done_cycle", cyc, exp_done);
                check("handshakes", hs, NPIX);
                check("read_count", rd_q.size(), NPIX * NT);
            end
        end
        if (!fin) check("done_timeout", 0, 1);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("busy_after", busy, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; bias = 8'd0; wgt_we = 1'b0;
        wgt_addr = 4'd0; wgt_data = 8'd0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_rd", img_rd, 0);
        check("rst_img_addr", img_addr, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_data", out_data, 0);
        reset = 1'b0;

        for (int i = 0; i < IMG_W*IMG_W; i++) img_mem[i] = 1;
        for (int i = 0; i < NT; i++) w_model[i] = 1;
        bias_model = 0;
        load_weights();
        run_pass(-1, -1, PASS_CYC, 1'b0);
        check("ones_value", first_data, 9);

        for (int i = 0; i < IMG_W*IMG_W; i++) img_mem[i] = i % 256;
        for (int i = 0; i < NT; i++) w_model[i] = (i == 4) ? 1 : 0;
        load_weights();
        run_pass(-1, -1, PASS_CYC, 1'b0);
        for (int t = 0; t < NT; t++)
            check("tap_addr", (t < rd_q.size()) ? rd_q[t] : -1, (t / K) * IMG_W + (t % K));
        check("centre_value", first_data, IMG_W + 1);

        for (int i = 0; i < IMG_W*IMG_W; i++) img_mem[i] = 255;
        for (int i = 0; i < NT; i++) w_model[i] = 127;
        bias_model = 127;
        load_weights();
        run_pass(-1, -1, PASS_CYC, 1'b0);
        check("sat_hi", first_data, 32767);

        for (int i = 0; i < NT; i++) w_model[i] = -128;
        bias_model = -128;
        load_weights();
        run_pass(-1, -1, PASS_CYC, 1'b0);
`ifdef CONV_SEQUENCER_RELU_EN
        check("sat_lo", first_data, 0);
`else
        check("sat_lo", first_data, -32768);
`endif

        for (int i = 0; i < IMG_W*IMG_W; i++) img_mem[i] = int'($urandom_range(255));
        for (int i = 0; i < NT; i++) w_model[i] = int'($urandom_range(255)) - 128;
        bias_model = int'($urandom_range(255)) - 128;
        load_weights();
        run_pass(3, -1, PASS_CYC + 5, 1'b1);

        run_pass(-1, 100, 0, 1'b0);

        for (int i = 0; i < NT; i++) w_model[i] = 0;
        bias_model = int'($urandom_range(255)) - 128;
        run_pass(-1, -1, PASS_CYC, 1'b0);
        check("zero_wgt_value", first_data, bias_model);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
